// File: rtl/code_sequencer_8p_if.sv
// Host-side table/control bus and channel outputs of the code sequencer.
// The master drives writes and control; the slave (the sequencer) drives playback status.
interface code_sequencer_8p_if #(
    parameter int CODE_W  = 32,
    parameter int ADDR_W  = 3,
    parameter int DWELL_W = 16,
    parameter int LOOP_W  = 8
) ();
    logic               iWR_EN;
    logic [ADDR_W-1:0]  iWR_ADDR;
    logic [CODE_W-1:0]  iWR_CODE;
    logic [DWELL_W-1:0] iWR_DWELL;
    logic [ADDR_W-1:0]  iLAST;
    logic [LOOP_W-1:0]  iLOOPS;
    logic               iExtMode;
    logic               iExtTrig;
    logic               iStart;
    logic               iAbort;
    logic [CODE_W-1:0]  oCode;
    logic               oValid;
    logic [ADDR_W-1:0]  oIndex;
    logic               oBusy;
    logic               oDone;
    logic               oErr;

    modport master (
        output iWR_EN, iWR_ADDR, iWR_CODE, iWR_DWELL, iLAST, iLOOPS,
               iExtMode, iExtTrig, iStart, iAbort,
        input  oCode, oValid, oIndex, oBusy, oDone, oErr
    );
    modport slave (
        input  iWR_EN, iWR_ADDR, iWR_CODE, iWR_DWELL, iLAST, iLOOPS,
               iExtMode, iExtTrig, iStart, iAbort,
        output oCode, oValid, oIndex, oBusy, oDone, oErr
    );
endinterface

// File: rtl/code_sequencer_8p.sv
// Timed/triggered playback of an 8-entry code table onto the PTS channel outputs.
// Outputs are registered from the next-state values so the first code appears one cycle after start.
module code_sequencer_8p #(
    parameter int CODE_W  = 32,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int DWELL_W = 16,
    parameter int LOOP_W  = 8
) (
    input  logic                  iClk,
    input  logic                  iRst,
    code_sequencer_8p_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_e;

    state_e             state_q, state_d;
    logic [CODE_W-1:0]  tbl_code_q  [DEPTH];
    logic [DWELL_W-1:0] tbl_dwell_q [DEPTH];
    logic [ADDR_W-1:0]  idx_q, idx_d, last_q, last_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [LOOP_W-1:0]  loop_q, loop_d;
    logic               ext_q, ext_d, err_q, err_d, trig_q;
    logic [CODE_W-1:0]  out_code_q, out_code_d;
    logic [ADDR_W-1:0]  out_idx_q, out_idx_d;
    logic               valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic               adv, rise;
    logic [ADDR_W-1:0]  nxt_idx;

    function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

    assign rise    = bus.iExtTrig & ~trig_q;
    assign nxt_idx = idx_q + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        loop_d  = loop_q;
        last_d  = last_q;
        ext_d   = ext_q;
        err_d   = err_q;
        adv     = 1'b0;
        if (bus.iWR_EN && busy_q) err_d = 1'b1;
        unique case (state_q)
            IDLE: if (bus.iStart && !bus.iAbort) begin
                state_d = PLAY;
                idx_d   = '0;
                cnt_d   = eff_dwell(tbl_dwell_q[0]);
                loop_d  = bus.iLOOPS;
                last_d  = bus.iLAST;
                ext_d   = bus.iExtMode;
                err_d   = 1'b0;
            end
            PLAY: if (bus.iAbort) begin
                state_d = IDLE;
            end else begin
                adv = ext_q ? rise : (cnt_q == DWELL_W'(1));
                if (!ext_q && !adv) cnt_d = cnt_q - DWELL_W'(1);
                if (adv) begin
                    if (idx_q != last_q) begin
                        idx_d = nxt_idx;
                        cnt_d = eff_dwell(tbl_dwell_q[nxt_idx]);
                    end else if (loop_q != LOOP_W'(1)) begin
                        // loop_q==0 means endless: never decremented, never reaches 1
                        idx_d = '0;
                        cnt_d = eff_dwell(tbl_dwell_q[0]);
                        if (loop_q != '0) loop_d = loop_q - LOOP_W'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        valid_d    = (state_d == PLAY);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        out_code_d = valid_d ? tbl_code_q[idx_d] : '0;
        out_idx_d  = valid_d ? idx_d : '0;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            loop_q     <= '0;
            last_q     <= '0;
            ext_q      <= 1'b0;
            err_q      <= 1'b0;
            trig_q     <= 1'b0;
            out_code_q <= '0;
            out_idx_q  <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            loop_q     <= loop_d;
            last_q     <= last_d;
            ext_q      <= ext_d;
            err_q      <= err_d;
            trig_q     <= bus.iExtTrig;
            out_code_q <= out_code_d;
            out_idx_q  <= out_idx_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_code_q[i]  <= '0;
                tbl_dwell_q[i] <= '0;
            end
        end else if (bus.iWR_EN && !busy_q) begin
            tbl_code_q[bus.iWR_ADDR]  <= bus.iWR_CODE;
            tbl_dwell_q[bus.iWR_ADDR] <= bus.iWR_DWELL;
        end
    end

    assign bus.oCode  = out_code_q;
    assign bus.oValid = valid_q;
    assign bus.oIndex = out_idx_q;
    assign bus.oBusy  = busy_q;
    assign bus.oDone  = done_q;
    assign bus.oErr   = err_q;
endmodule
